// File: rtl/lm_pkg.sv
// Purpose: shared constants and the 7-segment digit lookup for the level meter.
// Latency: n/a (package only).
// Backpressure: n/a (no flow control).
package lm_pkg;

    // Largest comparator count whose level still fits one decimal digit.
    localparam int MAX_COMPS = 9;

    // Active-high segment patterns, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Values 10..15 cannot occur for a legal comparator count; show blank.
    function automatic logic [6:0] seg7_of(input logic [3:0] value);
        logic [6:0] pat;
        case (value)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// Purpose: combinational 4-bit value to 7-segment pattern encoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: value (4-bit digit in), segs (7 active-high segments out, bit 0 = a).
module seg7_digit_enc
    import lm_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] segs
);

    assign segs = seg7_of(value);

endmodule

// File: rtl/level_meter_7seg.sv
// Purpose: thermometer comparator bank -> debounced level, peak hold, sticky bubble error, one 7-seg digit.
// Latency: comps held stable from capture edge 0 -> level at edge FILT_LEN+2 -> segs at edge FILT_LEN+3.
// Backpressure: none; samples every clock, outputs are free-running registers.
// Ports: clk, rst (sync, active-high); comps (async raw comparators); mode (0 live, 1 peak);
//        err_clr (clears sticky error); segs (7 segments); level_out, peak_out (CW bits); err (sticky).
module level_meter_7seg
    import lm_pkg::*;
#(
    parameter  int N_COMPS   = 5,
    parameter  int FILT_LEN  = 4,
    parameter  int PEAK_HOLD = 16,
    localparam int CW        = $clog2(N_COMPS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_COMPS-1:0] comps,
    input  logic               mode,
    input  logic               err_clr,
    output logic [6:0]         segs,
    output logic [CW-1:0]      level_out,
    output logic [CW-1:0]      peak_out,
    output logic               err
);

    // Stability counter only has to reach FILT_LEN-1; keep at least one bit.
    localparam int SW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int TW = $clog2(PEAK_HOLD + 1);

    generate
        if (N_COMPS < 1 || N_COMPS > MAX_COMPS || FILT_LEN < 1 || PEAK_HOLD < 1) begin : g_bad_param
            $error("level_meter_7seg: illegal parameter value");
        end
    endgenerate

    logic [N_COMPS-1:0] sync1;
    logic [N_COMPS-1:0] sc;
    logic [CW-1:0]      raw;
    logic               bubble;
    logic [CW-1:0]      cand;
    logic [SW-1:0]      stab;
    logic [TW-1:0]      timer;
    logic [3:0]         disp_val;
    logic [6:0]         dec_segs;

    // Popcount still counts bubbled bits; a bubble is any 1 sitting directly above a 0.
    always_comb begin
        raw    = '0;
        bubble = 1'b0;
        for (int i = 0; i < N_COMPS; i++) begin
            raw = raw + CW'(sc[i]);
        end
        for (int i = 1; i < N_COMPS; i++) begin
            if (sc[i] && !sc[i-1]) begin
                bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sc    <= '0;
        end else begin
            sync1 <= comps;
            sc    <= sync1;
        end
    end

    // Any change of raw restarts the run; the level is taken once the run
    // has lasted FILT_LEN further edges, after which stab saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand      <= '0;
            stab      <= '0;
            level_out <= '0;
        end else if (raw != cand) begin
            cand <= raw;
            stab <= '0;
        end else if (stab == SW'(FILT_LEN - 1)) begin
            level_out <= cand;
        end else begin
            stab <= stab + SW'(1);
        end
    end

    // Peak jumps straight back to the live level when the hold expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_out <= '0;
            timer    <= '0;
        end else if (level_out > peak_out) begin
            peak_out <= level_out;
            timer    <= TW'(PEAK_HOLD);
        end else if (timer == '0) begin
            peak_out <= level_out;
        end else begin
            timer <= timer - TW'(1);
        end
    end

    // A bubble on the same edge as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (bubble) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    assign disp_val = 4'(mode ? peak_out : level_out);

    seg7_digit_enc u_enc (
        .value (disp_val),
        .segs  (dec_segs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            segs <= SEG_BLANK;
        end else begin
            segs <= err ? SEG_E : dec_segs;
        end
    end

endmodule

// File: tb/tb_level_meter_7seg.sv
module tb_level_meter_7seg;

    localparam int FILT_LEN  = 4;
    localparam int PEAK_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] comps = 5'd0;
    logic       mode = 1'b0;
    logic       err_clr = 1'b0;
    logic [6:0] segs;
    logic [2:0] level_out;
    logic [2:0] peak_out;
    logic       err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    level_meter_7seg #(
        .N_COMPS   (5),
        .FILT_LEN  (FILT_LEN),
        .PEAK_HOLD (PEAK_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .comps     (comps),
        .mode      (mode),
        .err_clr   (err_clr),
        .segs      (segs),
        .level_out (level_out),
        .peak_out  (peak_out),
        .err       (err)
    );

    // ---------------- behavioural reference ----------------
    // Level: accepted once the last FILT_LEN+1 per-edge counts agree.
    // Counts are taken from comps delayed by two edges.
    logic [4:0] m_s1 = 5'd0;
    logic [4:0] m_s2 = 5'd0;
    int         hist[$];
    int         m_level = 0;
    int         m_peak = 0;
    int         m_hold = 0;
    bit         m_err = 1'b0;
    logic [6:0] m_segs = 7'h00;

    function automatic logic [6:0] seg_exp(input int v);
        case (v)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic model_step();
        int raw;
        bit same;
        if (rst) begin
            m_s1 = 5'd0; m_s2 = 5'd0;
            m_level = 0; m_peak = 0; m_hold = 0; m_err = 1'b0; m_segs = 7'h00;
            hist.delete();
            hist.push_back(0);
        end else begin
            raw = $countones(m_s2);
            hist.push_back(raw);
            if (hist.size() > FILT_LEN + 1) void'(hist.pop_front());
            same = (hist.size() == FILT_LEN + 1);
            foreach (hist[k]) if (hist[k] != raw) same = 1'b0;
            m_segs = m_err ? 7'h79 : seg_exp(mode ? m_peak : m_level);
            if (m_level > m_peak) begin
                m_peak = m_level;
                m_hold = PEAK_HOLD;
            end else if (m_hold == 0) begin
                m_peak = m_level;
            end else begin
                m_hold = m_hold - 1;
            end
            if (m_s2 != 5'((1 << raw) - 1)) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (same) m_level = raw;
            m_s2 = m_s1;
            m_s1 = comps;
        end
    endtask

    initial begin
        hist.push_back(0);
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; comps = 5'd0; mode = 1'b0; err_clr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (segs !== 7'h00 || level_out !== 3'd0 || peak_out !== 3'd0 || err !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold segs=%h lvl=%0d peak=%0d err=%0b exp 00/0/0/0", segs, level_out, peak_out, err);
            end
        end
        rst = 1'b0;
        tick(1);
        checks++;
        if (segs !== 7'h3F || level_out !== 3'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_release segs=%h lvl=%0d err=%0b exp 3f/0/0", segs, level_out, err);
        end
    endtask

    task automatic test_step();
        comps = 5'b00111;
        tick(6);
        checks++;
        if (level_out !== 3'd0) begin
            failures++; $display("FAIL step_early_level got=%0d exp=0", level_out);
        end
        tick(1);
        checks++;
        if (level_out !== 3'd3 || segs !== 7'h3F || peak_out !== 3'd0) begin
            failures++;
            $display("FAIL step_edge6 lvl=%0d segs=%h peak=%0d exp 3/3f/0", level_out, segs, peak_out);
        end
        tick(1);
        checks++;
        if (segs !== 7'h4F || peak_out !== 3'd3) begin
            failures++; $display("FAIL step_edge7 segs=%h peak=%0d exp 4f/3", segs, peak_out);
        end
    endtask

    task automatic test_glitch();
        comps = 5'd0;
        tick(30);
        checks++;
        if (level_out !== 3'd0 || peak_out !== 3'd0) begin
            failures++; $display("FAIL glitch_idle lvl=%0d peak=%0d exp 0/0", level_out, peak_out);
        end
        comps = 5'b00111;
        tick(3);
        comps = 5'd0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            checks++;
            if (level_out !== 3'd0 || segs !== 7'h3F) begin
                failures++; $display("FAIL glitch_reject cyc=%0d lvl=%0d segs=%h exp 0/3f", i, level_out, segs);
            end
        end
    endtask

    task automatic test_peak_hold();
        bit found = 1'b0;
        mode = 1'b1;
        comps = 5'b11111;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (level_out === 3'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL peak_wait_level5 timeout lvl=%0d exp=5", level_out);
        end
        comps = 5'b00001;
        tick(10);
        checks++;
        if (level_out !== 3'd1 || segs !== 7'h6D || peak_out !== 3'd5) begin
            failures++; $display("FAIL peak_holding lvl=%0d segs=%h peak=%0d exp 1/6d/5", level_out, segs, peak_out);
        end
        tick(7);
        checks++;
        if (peak_out !== 3'd5) begin
            failures++; $display("FAIL peak_last_hold got=%0d exp=5", peak_out);
        end
        tick(1);
        checks++;
        if (peak_out !== 3'd1 || segs !== 7'h6D) begin
            failures++; $display("FAIL peak_decay peak=%0d segs=%h exp 1/6d", peak_out, segs);
        end
        tick(1);
        checks++;
        if (segs !== 7'h06) begin
            failures++; $display("FAIL peak_decay_segs got=%h exp=06", segs);
        end
        mode = 1'b0;
    endtask

    task automatic test_bubble();
        comps = 5'd0;
        tick(30);
        comps = 5'b00101;
        tick(2);
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL bubble_early_err got=%0b exp=0", err);
        end
        tick(1);
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL bubble_err got=%0b exp=1", err);
        end
        tick(1);
        checks++;
        if (segs !== 7'h79) begin
            failures++; $display("FAIL bubble_segs got=%h exp=79", segs);
        end
        comps = 5'b00111;
        tick(10);
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL bubble_sticky got=%0b exp=1", err);
        end
        err_clr = 1'b1;
        tick(1);
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL bubble_clear got=%0b exp=0", err);
        end
        err_clr = 1'b0;
        tick(1);
        checks++;
        if (segs !== 7'h4F) begin
            failures++; $display("FAIL bubble_clear_segs got=%h exp=4f", segs);
        end
    endtask

    task automatic test_set_clear_and_reset();
        comps = 5'b00101;
        err_clr = 1'b1;
        tick(3);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if (err !== 1'b1) begin
                failures++; $display("FAIL set_over_clear cyc=%0d got=%0b exp=1", i, err);
            end
        end
        err_clr = 1'b0;
        comps = 5'b00111;
        tick(4);
        rst = 1'b1;
        tick(1);
        checks++;
        if (level_out !== 3'd0 || segs !== 7'h00 || peak_out !== 3'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset lvl=%0d segs=%h peak=%0d err=%0b exp 0/00/0/0", level_out, segs, peak_out, err);
        end
        rst = 1'b0;
        tick(1);
        checks++;
        if (segs !== 7'h3F) begin
            failures++; $display("FAIL midop_release_segs got=%h exp=3f", segs);
        end
        tick(5);
        checks++;
        if (level_out !== 3'd0) begin
            failures++; $display("FAIL midop_restart_early got=%0d exp=0", level_out);
        end
        tick(1);
        checks++;
        if (level_out !== 3'd3) begin
            failures++; $display("FAIL midop_restart_level got=%0d exp=3", level_out);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        int t;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            checks++;
            if (segs !== m_segs || level_out !== 3'(m_level) || peak_out !== 3'(m_peak) || err !== m_err) begin
                failures++;
                $display("FAIL random cyc=%0d segs=%h/%h lvl=%0d/%0d peak=%0d/%0d err=%0b/%0b (got/exp)",
                         cyc, segs, m_segs, level_out, m_level, peak_out, m_peak, err, m_err);
            end
            rst = ($urandom_range(0, 299) == 0);
            if (hold == 0) begin
                hold = $urandom_range(1, 10);
                if ($urandom_range(0, 9) < 2) begin
                    comps = 5'($urandom);
                end else begin
                    t = (1 << $urandom_range(0, 5)) - 1;
                    comps = 5'(t);
                end
            end else begin
                hold--;
            end
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            err_clr = ($urandom_range(0, 7) == 0);
        end
        rst = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_peak_hold();
        test_bubble();
        test_set_clear_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
